// File: rtl/palette_bank_if.sv
// CPU register bus and pixel lookup bus of the palette bank.
// master = bus decoder / pixel pipeline, slave = palette_bank.
interface palette_bank_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_rdata_oe;

    logic              pix_valid;
    logic [2:0]        pix_pal;
    logic [1:0]        pix_idx;
    logic              shade_valid;
    logic [1:0]        shade;
    logic [14:0]       rgb;

    modport master (
        output cpu_addr, cpu_wr, cpu_rd, cpu_wdata, pix_valid, pix_pal, pix_idx,
        input  cpu_rdata, cpu_rdata_oe, shade_valid, shade, rgb
    );

    modport slave (
        input  cpu_addr, cpu_wr, cpu_rd, cpu_wdata, pix_valid, pix_pal, pix_idx,
        output cpu_rdata, cpu_rdata_oe, shade_valid, shade, rgb
    );
endinterface

// File: rtl/palette_bank.sv
// NUM_PAL monochrome palettes plus byte-addressed colour RAM behind an index/data port.
// Define CRAM_LOCK_EN to add the cram_lock input that blocks CRAM data-port access.
module palette_bank #(
    parameter int         NUM_PAL    = 3,
    parameter int         CRAM_BYTES = 64,
    parameter logic [7:0] PAL_RESET  = 8'h00,
    parameter int         ADDR_W     = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
`ifdef CRAM_LOCK_EN
    input  logic                 cram_lock,
`endif
    palette_bank_if.slave        bus,
    output logic [8*NUM_PAL-1:0] pal_d
);
    localparam int         IDX_W    = $clog2(CRAM_BYTES);
    localparam int         NCPAL    = CRAM_BYTES / 8;
    // Index bits that live in the 7-bit field below autoinc; the rest read as 1.
    localparam logic [6:0] IDX_MASK = 7'((1 << IDX_W) - 1);

    logic [NUM_PAL-1:0][7:0] pal_q;
    logic [7:0]              cram [CRAM_BYTES];
    logic [IDX_W-1:0]        cram_idx;
    logic                    autoinc;
    logic                    locked;

    logic                    wr_idx, wr_dat, rd_go;
    logic [7:0]              rd_mux;
    logic [IDX_W-1:0]        pix_base, pix_base_hi;
    logic [1:0]              pix_shade;

`ifdef CRAM_LOCK_EN
    assign locked = cram_lock;
`else
    assign locked = 1'b0;
`endif

    assign pal_d  = pal_q;
    assign wr_idx = bus.cpu_wr && (int'(bus.cpu_addr) == NUM_PAL);
    assign wr_dat = bus.cpu_wr && (int'(bus.cpu_addr) == NUM_PAL + 1);
    // A write in the same cycle wins; the read is dropped entirely.
    assign rd_go  = bus.cpu_rd && !bus.cpu_wr;

    always_comb begin
        rd_mux = 8'hFF;
        for (int k = 0; k < NUM_PAL; k++)
            if (int'(bus.cpu_addr) == k) rd_mux = pal_q[k];
        if (int'(bus.cpu_addr) == NUM_PAL)
            rd_mux = {autoinc, (7'(cram_idx) & IDX_MASK) | ~IDX_MASK};
        if (int'(bus.cpu_addr) == NUM_PAL + 1)
            rd_mux = locked ? 8'hFF : cram[cram_idx];
    end

    always_comb begin
        pix_base    = IDX_W'((int'(bus.pix_pal) % NCPAL) * 8 + int'(bus.pix_idx) * 2);
        pix_base_hi = {pix_base[IDX_W-1:1], 1'b1};
        pix_shade   = 2'b00;
        for (int k = 0; k < NUM_PAL; k++)
            if (int'(bus.pix_pal) == k) pix_shade = pal_q[k][int'(bus.pix_idx) * 2 +: 2];
    end

    // All lookup/readback registers sample storage before this edge's write lands,
    // so a same-cycle collision returns the old value.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pal_q            <= {NUM_PAL{PAL_RESET}};
            cram_idx         <= '0;
            autoinc          <= 1'b0;
            for (int i = 0; i < CRAM_BYTES; i++) cram[i] <= 8'hFF;
            bus.cpu_rdata    <= 8'hFF;
            bus.cpu_rdata_oe <= 1'b0;
            bus.shade_valid  <= 1'b0;
            bus.shade        <= 2'b00;
            bus.rgb          <= '0;
        end else begin
            for (int k = 0; k < NUM_PAL; k++)
                if (bus.cpu_wr && int'(bus.cpu_addr) == k) pal_q[k] <= bus.cpu_wdata;

            if (wr_idx) begin
                autoinc  <= bus.cpu_wdata[7];
                cram_idx <= IDX_W'(bus.cpu_wdata[6:0] & IDX_MASK);
            end
            if (wr_dat) begin
                if (!locked) cram[cram_idx] <= bus.cpu_wdata;
                if (autoinc) cram_idx <= cram_idx + 1'b1;
            end

            bus.cpu_rdata_oe <= rd_go;
            if (rd_go) bus.cpu_rdata <= rd_mux;

            bus.shade_valid <= bus.pix_valid;
            if (bus.pix_valid) begin
                bus.shade <= pix_shade;
                bus.rgb   <= {cram[pix_base_hi][6:0], cram[pix_base]};
            end
        end
    end
endmodule

// File: tb/tb_palette_bank.sv
// Directed bench for palette_bank: per-cycle compare against a behavioural model
// plus literal expectations taken from hand calculation.
module tb_palette_bank;
    localparam int         NUM_PAL    = 3;
    localparam int         CRAM_BYTES = 64;
    localparam logic [7:0] PAL_RESET  = 8'h00;
    localparam int         ADDR_W     = 4;
    localparam int         OFF_IDX    = NUM_PAL;
    localparam int         OFF_DAT    = NUM_PAL + 1;

    logic                 clk  = 1'b0;
    logic                 nrst = 1'b0;
    logic [8*NUM_PAL-1:0] pal_d;
    logic                 m_lock;
`ifdef CRAM_LOCK_EN
    logic                 cram_lock = 1'b0;
    assign m_lock = cram_lock;
`else
    assign m_lock = 1'b0;
`endif

    palette_bank_if #(.ADDR_W(ADDR_W)) bus ();

    palette_bank #(
        .NUM_PAL(NUM_PAL), .CRAM_BYTES(CRAM_BYTES), .PAL_RESET(PAL_RESET), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .nrst(nrst),
`ifdef CRAM_LOCK_EN
        .cram_lock(cram_lock),
`endif
        .bus(bus),
        .pal_d(pal_d)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_pal  [NUM_PAL];
    logic [7:0]  m_cram [CRAM_BYTES];
    int          m_idx;
    logic        m_ai;
    logic [7:0]  e_rdata;
    logic        e_oe, e_sv;
    logic [1:0]  e_shade;
    logic [14:0] e_rgb;

    function automatic logic [7:0] m_read(input int a);
        if (a < NUM_PAL)  return m_pal[a];
        if (a == OFF_IDX) return {m_ai, 7'(m_idx)} | (8'h7F & ~8'(CRAM_BYTES - 1));
        if (a == OFF_DAT) return m_lock ? 8'hFF : m_cram[m_idx];
        return 8'hFF;
    endfunction

    function automatic logic [1:0] m_shade(input int p, input int i);
        if (p >= NUM_PAL) return 2'b00;
        return 2'((m_pal[p] >> (2 * i)) & 8'h03);
    endfunction

    function automatic logic [14:0] m_rgb(input int p, input int i);
        int base;
        base = (p % (CRAM_BYTES / 8)) * 8 + i * 2;
        return {m_cram[base + 1][6:0], m_cram[base]};
    endfunction

    function automatic logic [8*NUM_PAL-1:0] m_pal_d();
        logic [8*NUM_PAL-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_PAL; k++) v[8*k +: 8] = m_pal[k];
        return v;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < NUM_PAL; k++) m_pal[k] <= PAL_RESET;
            for (int i = 0; i < CRAM_BYTES; i++) m_cram[i] <= 8'hFF;
            m_idx   <= 0;
            m_ai    <= 1'b0;
            e_rdata <= 8'hFF;
            e_oe    <= 1'b0;
            e_sv    <= 1'b0;
            e_shade <= 2'b00;
            e_rgb   <= '0;
        end else begin
            e_oe <= bus.cpu_rd && !bus.cpu_wr;
            if (bus.cpu_rd && !bus.cpu_wr) e_rdata <= m_read(int'(bus.cpu_addr));
            e_sv <= bus.pix_valid;
            if (bus.pix_valid) begin
                e_shade <= m_shade(int'(bus.pix_pal), int'(bus.pix_idx));
                e_rgb   <= m_rgb(int'(bus.pix_pal), int'(bus.pix_idx));
            end
            if (bus.cpu_wr) begin
                if (int'(bus.cpu_addr) < NUM_PAL) m_pal[int'(bus.cpu_addr)] <= bus.cpu_wdata;
                else if (int'(bus.cpu_addr) == OFF_IDX) begin
                    m_ai  <= bus.cpu_wdata[7];
                    m_idx <= int'(bus.cpu_wdata[6:0]) % CRAM_BYTES;
                end else if (int'(bus.cpu_addr) == OFF_DAT) begin
                    if (!m_lock) m_cram[m_idx] <= bus.cpu_wdata;
                    if (m_ai) m_idx <= (m_idx + 1) % CRAM_BYTES;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (nrst) begin
            chk("cpu_rdata_oe", 32'(bus.cpu_rdata_oe), 32'(e_oe));
            chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_rdata));
            chk("shade_valid", 32'(bus.shade_valid), 32'(e_sv));
            chk("shade", 32'(bus.shade), 32'(e_shade));
            chk("rgb", 32'(bus.rgb), 32'(e_rgb));
            chk("pal_d", 32'(pal_d), 32'(m_pal_d()));
        end
    end

    // ---------------- stimulus (tasks start and end at posedge+2) ----------------
    task automatic cpu_write(input int a, input logic [7:0] d);
        bus.cpu_addr = ADDR_W'(a); bus.cpu_wdata = d; bus.cpu_wr = 1'b1;
        @(posedge clk); #2;
        bus.cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input int a, output logic [7:0] d, output logic oe);
        bus.cpu_addr = ADDR_W'(a); bus.cpu_rd = 1'b1;
        @(posedge clk); #2;
        bus.cpu_rd = 1'b0;
        @(negedge clk);
        d = bus.cpu_rdata; oe = bus.cpu_rdata_oe;
        @(posedge clk); #2;
    endtask

    task automatic lookup(input int p, input int i, output logic [1:0] sh, output logic [14:0] c);
        bus.pix_pal = 3'(p); bus.pix_idx = 2'(i); bus.pix_valid = 1'b1;
        @(posedge clk); #2;
        bus.pix_valid = 1'b0;
        @(negedge clk);
        sh = bus.shade; c = bus.rgb;
        @(posedge clk); #2;
    endtask

    task automatic rd_expect(input string name, input int a, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        cpu_read(a, d, oe);
        chk({name, "_oe"}, 32'(oe), 32'd1);
        chk(name, 32'(d), 32'(exp));
    endtask

    initial begin
        logic [1:0]  sh;
        logic [14:0] c;
        bus.cpu_addr = '0; bus.cpu_wr = 0; bus.cpu_rd = 0; bus.cpu_wdata = '0;
        bus.pix_valid = 0; bus.pix_pal = '0; bus.pix_idx = '0;
        repeat (3) @(posedge clk);
        #2 nrst = 1'b1;
        @(negedge clk);
        chk("rst_pal_d", 32'(pal_d), 32'h0);
        chk("rst_oe", 32'(bus.cpu_rdata_oe), 32'd0);
        chk("rst_rdata", 32'(bus.cpu_rdata), 32'hFF);
        @(posedge clk); #2;
        rd_expect("rst_index", OFF_IDX, 8'h40);
        rd_expect("rst_cram0", OFF_DAT, 8'hFF);
        rd_expect("unmapped", 15, 8'hFF);

        // monochrome palette write and shade lookup
        cpu_write(0, 8'hE4);
        rd_expect("pal0", 0, 8'hE4);
        for (int i = 0; i < 4; i++) begin
            lookup(0, i, sh, c);
            chk($sformatf("shade_idx%0d", i), 32'(sh), 32'(i));
        end

        // CRAM autoinc with wrap
        cpu_write(OFF_IDX, 8'hBE);
        cpu_write(OFF_DAT, 8'h1F);
        cpu_write(OFF_DAT, 8'h7C);
        cpu_write(OFF_DAT, 8'h11);
        rd_expect("index_wrap", OFF_IDX, 8'hC1);
        rd_expect("cram1", OFF_DAT, 8'hFF);
        rd_expect("index_no_rd_inc", OFF_IDX, 8'hC1);
        lookup(7, 3, sh, c);
        chk("rgb_pal7_idx3", 32'(c), 32'h7C1F);
        chk("shade_pal7", 32'(sh), 32'd0);
        lookup(0, 0, sh, c);
        chk("rgb_pal0_idx0", 32'(c), 32'h7F11);

        // write+read collision and same-cycle lookup of the palette being written
        cpu_write(1, 8'h1B);
        bus.cpu_addr = 4'd1; bus.cpu_wdata = 8'h55; bus.cpu_wr = 1; bus.cpu_rd = 1;
        bus.pix_pal = 3'd1; bus.pix_idx = 2'd0; bus.pix_valid = 1;
        @(posedge clk); #2;
        bus.cpu_wr = 0; bus.cpu_rd = 0; bus.pix_valid = 0;
        @(negedge clk);
        chk("wr_rd_no_oe", 32'(bus.cpu_rdata_oe), 32'd0);
        chk("collide_old_shade", 32'(bus.shade), 32'd3);
        @(posedge clk); #2;
        lookup(1, 0, sh, c);
        chk("new_shade", 32'(sh), 32'd1);
        chk("pal_d_after", 32'(pal_d), 32'h0055E4);

        // back-to-back sweep of every palette select and index
        for (int p = 0; p < 8; p++)
            for (int i = 0; i < 4; i++) begin
                bus.pix_pal = 3'(p); bus.pix_idx = 2'(i); bus.pix_valid = 1'b1;
                @(posedge clk); #2;
            end
        bus.pix_valid = 1'b0;

`ifdef CRAM_LOCK_EN
        cpu_write(OFF_IDX, 8'h84);
        cram_lock = 1'b1;
        cpu_write(OFF_DAT, 8'h00);
        rd_expect("lock_index", OFF_IDX, 8'hC5);
        rd_expect("lock_data", OFF_DAT, 8'hFF);
        cram_lock = 1'b0;
`endif
        cpu_write(OFF_IDX, 8'h04);
        rd_expect("cram4_untouched", OFF_DAT, 8'hFF);
        cpu_write(OFF_DAT, 8'h5A);
        rd_expect("cram4_written", OFF_DAT, 8'h5A);
        rd_expect("index_no_ai", OFF_IDX, 8'h44);

        // asynchronous reset right after a read completes
        bus.cpu_addr = 4'd0; bus.cpu_rd = 1'b1;
        @(posedge clk); #2;
        bus.cpu_rd = 1'b0;
        #1 nrst = 1'b0;
        #1;
        chk("async_rst_oe", 32'(bus.cpu_rdata_oe), 32'd0);
        chk("async_rst_rdata", 32'(bus.cpu_rdata), 32'hFF);
        chk("async_rst_pal_d", 32'(pal_d), 32'h0);
        chk("async_rst_rgb", 32'(bus.rgb), 32'h0);
        @(posedge clk); #2 nrst = 1'b1;
        rd_expect("post_rst_index", OFF_IDX, 8'h40);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit %0d ns", 200000);
        $fatal(1);
    end
endmodule
